rtc_bcd: RTL and testbench
==========================

RTC_BCD -- requirements
Module: rtc_bcd

Interface
REQ-001 SHALL have parameter HOURS_24, default 1, 1 = hours 00..23, 0 = 12-hour mode (hours 12,01..11 plus pm flag).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port tick  input  1  1 Hz square wave (clk_1hz clk_out), synchronous to clk.
REQ-005 SHALL have port run  input  1  1 = count on tick edges, 0 = hold time.
REQ-006 SHALL have port load  input  1  one-cycle strobe: write load_* into the time registers.
REQ-007 SHALL have ports load_hh, load_mm, load_ss  input  8 each  packed BCD {tens,units}.
REQ-008 SHALL have port load_pm  input  1  pm value for load; ignored when HOURS_24=1.
REQ-009 SHALL have ports hh, mm, ss  output  8 each  current time, packed BCD, registered.
REQ-010 SHALL have port pm  output  1  registered; constant 0 when HOURS_24=1.
REQ-011 SHALL have port sec_pulse  output  1  one-cycle pulse per second advanced.
REQ-012 SHALL have port day_pulse  output  1  one-cycle pulse on day rollover.
REQ-013 SHALL have port load_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-014 SHALL register tick into tick_q every cycle regardless of run/load; edge = tick & ~tick_q.
REQ-015 SHALL advance time by one second at the clk edge where edge=1, run=1, load=0; sec_pulse SHALL be 1 during the following cycle only.
REQ-016 SHALL advance at most once per tick rising edge; tick held high any number of cycles gives one advance.
REQ-017 SHALL not advance and SHALL not assert sec_pulse when run=0; edges occurring while run=0 are discarded, not queued.
REQ-018 SHALL roll ss 59->00 with carry into mm; mm 59->00 with carry into hh; BCD units 9->0 with tens increment.
REQ-019 HOURS_24=1: hh SHALL roll 23->00; day_pulse SHALL assert on the 23:59:59->00:00:00 advance, coincident with sec_pulse.
REQ-020 HOURS_24=0: hh sequence 12,01,02..11,12; pm SHALL toggle on the 11:59:59->12:00:00 advance; day_pulse SHALL assert only on 11:59:59 pm -> 12:00:00 am.
REQ-021 SHALL validate load: every BCD digit <=9, ss<=59, mm<=59, hh<=23 (24h) or hh in 01..12 (12h).
REQ-022 A valid load SHALL update hh/mm/ss/pm at the load clk edge; pm SHALL take load_pm only in 12h mode.
REQ-023 An invalid load SHALL leave all time registers unchanged and pulse load_err for one cycle.
REQ-024 load SHALL have priority over a same-cycle tick edge; that edge SHALL be discarded (no advance, no sec_pulse), valid or invalid load alike.
REQ-025 day_pulse, sec_pulse, load_err SHALL be 0 in every cycle not named above.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, force ss=00, mm=00, pm=0, tick_q=0, sec_pulse=0, day_pulse=0, load_err=0, hh=00 (HOURS_24=1) or 12 (HOURS_24=0).
REQ-027 Reset asserted mid-count SHALL discard any pending edge; after release, tick already high SHALL count as a rising edge on the first clk edge.
REQ-028 Outputs SHALL hold reset values while rst_n=0 irrespective of tick, run, load.

Verification
REQ-029 24h, run=1, load 23:59:58, two tick rising edges -> 23:59:59 then 00:00:00; day_pulse high exactly one cycle with the second sec_pulse.
REQ-030 12h, load 11:59:59 pm=0, one edge -> 12:00:00 pm=1, day_pulse=0; reload 11:59:59 pm=1, one edge -> 12:00:00 pm=0, day_pulse=1.
REQ-031 tick held high 10 cycles, run=1 from 00:00:00 -> exactly one advance to 00:00:01, one sec_pulse.
REQ-032 load 00:60:00 (24h) or hh=00 (12h) or digit 0xA -> time unchanged, load_err one cycle; load coincident with tick edge -> loaded value shown, no advance.
REQ-033 run=0 across 3 tick edges -> time and sec_pulse unchanged; run=1 restored -> next edge advances by exactly 1 s.
REQ-034 rst_n low mid-count at 12:34:56, asserted between clk edges -> outputs reach reset values before the next clk edge; after release, counting resumes from reset value.

Source files
------------

// File: rtl/rtc_bcd.sv
// -----------------------------------------------------------------------------
// rtc_bcd -- real-time clock kept in packed BCD.
//
// The clock counts hh:mm:ss once per rising edge of a 1 Hz tick that is
// synchronous to clk. It supports 24-hour mode (00..23) and 12-hour mode
// (12,01..11 plus a pm flag). A load strobe writes a new time. The load is
// checked for legal BCD and legal ranges, and an illegal load is rejected
// with a one-cycle error pulse.
//
// Parameters
//   HOURS_24   1 = 24-hour mode, 0 = 12-hour mode with pm flag
// Ports
//   clk        system clock; all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   tick       1 Hz square wave, synchronous to clk
//   run        1 = count on tick rising edges, 0 = hold (edges discarded)
//   load       one-cycle strobe: write load_hh/mm/ss/pm into the time
//   load_hh/mm/ss  packed BCD {tens,units}
//   load_pm    pm value for load (ignored in 24-hour mode)
//   hh/mm/ss   current time, packed BCD, registered
//   pm         pm flag, registered; constant 0 in 24-hour mode
//   sec_pulse  one-cycle pulse after each one-second advance
//   day_pulse  one-cycle pulse after the day rollover advance
//   load_err   one-cycle pulse after a rejected load
// -----------------------------------------------------------------------------
module rtc_bcd #(
  parameter int HOURS_24 = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       load_pm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       sec_pulse,
  output logic       day_pulse,
  output logic       load_err
);

  localparam bit         MODE24   = (HOURS_24 != 0);
  localparam logic [7:0] HH_RESET = MODE24 ? 8'h00 : 8'h12;

  logic       tick_q;
  logic       advance;
  logic       load_ok;
  logic [7:0] ss_nxt;
  logic [7:0] mm_nxt;
  logic [7:0] hh_nxt;
  logic       pm_nxt;
  logic       day_nxt;

  // Increment a packed BCD byte; callers handle the wrap value themselves.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // A load takes priority over a same-cycle edge. Because tick_q still
  // samples tick in that cycle, the edge is consumed and is not replayed.
  assign advance = tick & ~tick_q & run & ~load;

  // Load validation. A tens digit <= 5 already implies a legal BCD digit, so
  // only the unit digits need the separate <= 9 check.
  always_comb begin : validate
    load_ok = (load_ss[7:4] <= 4'd5) && (load_ss[3:0] <= 4'd9) &&
              (load_mm[7:4] <= 4'd5) && (load_mm[3:0] <= 4'd9) &&
              (load_hh[3:0] <= 4'd9);
    if (MODE24) begin
      load_ok = load_ok &&
                ((load_hh[7:4] <= 4'd1) ||
                 ((load_hh[7:4] == 4'd2) && (load_hh[3:0] <= 4'd3)));
    end else begin
      load_ok = load_ok &&
                (((load_hh[7:4] == 4'd0) && (load_hh[3:0] != 4'd0)) ||
                 ((load_hh[7:4] == 4'd1) && (load_hh[3:0] <= 4'd2)));
    end
  end

  // Time one second from now, with the ripple carry ss -> mm -> hh.
  always_comb begin : count_next
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    ss_nxt  = ss;
    mm_nxt  = mm;
    hh_nxt  = hh;
    pm_nxt  = pm;
    day_nxt = 1'b0;
    if (ss == 8'h59) begin
      ss_nxt = 8'h00;
      if (mm == 8'h59) begin
        mm_nxt = 8'h00;
        if (MODE24) begin
          if (hh == 8'h23) begin
            hh_nxt  = 8'h00;
            day_nxt = 1'b1;
          end else begin
            hh_nxt = bcd_inc(hh);
          end
        end else begin
          if (hh == 8'h12) begin
            hh_nxt = 8'h01;
          end else begin
            hh_nxt = bcd_inc(hh);
            // The 11 -> 12 step flips am/pm. It is a new day only when
            // the clock is leaving pm.
            if (hh == 8'h11) begin
              pm_nxt  = ~pm;
              day_nxt = pm;
            end
          end
        end
      end else begin
        mm_nxt = bcd_inc(mm);
      end
    end else begin
      ss_nxt = bcd_inc(ss);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q    <= 1'b0;
      hh        <= HH_RESET;
      mm        <= 8'h00;
      ss        <= 8'h00;
      pm        <= 1'b0;
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      tick_q    <= tick;
      sec_pulse <= advance;
      day_pulse <= advance & day_nxt;
      load_err  <= load & ~load_ok;
      if (load) begin
        if (load_ok) begin
          hh <= load_hh;
          mm <= load_mm;
          ss <= load_ss;
          pm <= MODE24 ? 1'b0 : load_pm;
        end
      end else if (advance) begin
        hh <= hh_nxt;
        mm <= mm_nxt;
        ss <= ss_nxt;
        pm <= MODE24 ? 1'b0 : pm_nxt;
      end
    end
  end

endmodule

// File: tb/tb_rtc_bcd.sv
// -----------------------------------------------------------------------------
// tb_rtc_bcd -- testbench for rtc_bcd in both hour modes.
//
// A 24-hour instance and a 12-hour instance share the same stimulus. The
// reference model stores each clock as plain seconds-of-day (0..86399). It
// derives the expected display, pm flag and pulses from that count with
// integer arithmetic. Every output of both instances is compared at each
// falling clk edge.
// -----------------------------------------------------------------------------
module tb_rtc_bcd;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       run = 1'b0;
  logic       load = 1'b0;
  logic       load_pm = 1'b0;
  logic [7:0] load_hh = 8'h00;
  logic [7:0] load_mm = 8'h00;
  logic [7:0] load_ss = 8'h00;

  logic [7:0] hh_a, mm_a, ss_a, hh_b, mm_b, ss_b;
  logic       pm_a, sec_a, day_a, err_a, pm_b, sec_b, day_b, err_b;

  int checks = 0;
  int errors = 0;

  // Model state. Index 0 is the 24-hour clock and index 1 the 12-hour clock.
  int secs [2];
  bit exp_sec [2];
  bit exp_day [2];
  bit exp_err [2];
  bit m_tick_q;

  always #5 clk = ~clk;

  rtc_bcd #(.HOURS_24(1)) dut_24 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss), .load_pm(load_pm),
    .hh(hh_a), .mm(mm_a), .ss(ss_a), .pm(pm_a),
    .sec_pulse(sec_a), .day_pulse(day_a), .load_err(err_a)
  );

  rtc_bcd #(.HOURS_24(0)) dut_12 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss), .load_pm(load_pm),
    .hh(hh_b), .mm(mm_b), .ss(ss_b), .pm(pm_b),
    .sec_pulse(sec_b), .day_pulse(day_b), .load_err(err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic bit load_valid(input bit mode12, input logic [7:0] h,
                                    input logic [7:0] m, input logic [7:0] s);
    int hv, mv, sv;
    if (h[3:0] > 9 || h[7:4] > 9 || m[3:0] > 9 || m[7:4] > 9 ||
        s[3:0] > 9 || s[7:4] > 9) return 1'b0;
    hv = int'(h[7:4]) * 10 + int'(h[3:0]);
    mv = int'(m[7:4]) * 10 + int'(m[3:0]);
    sv = int'(s[7:4]) * 10 + int'(s[3:0]);
    if (mv > 59 || sv > 59) return 1'b0;
    if (mode12) return (hv >= 1 && hv <= 12);
    return (hv <= 23);
  endfunction

  function automatic int load_secs(input bit mode12, input logic [7:0] h,
                                   input logic [7:0] m, input logic [7:0] s,
                                   input bit p);
    int hv;
    hv = int'(h[7:4]) * 10 + int'(h[3:0]);
    if (mode12) hv = (hv % 12) + (p ? 12 : 0);
    return hv * 3600 + (int'(m[7:4]) * 10 + int'(m[3:0])) * 60 +
           int'(s[7:4]) * 10 + int'(s[3:0]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      secs[i]    = 0;
      exp_sec[i] = 1'b0;
      exp_day[i] = 1'b0;
      exp_err[i] = 1'b0;
    end
    m_tick_q = 1'b0;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      int hr, hdisp;
      string n;
      logic [7:0] o_hh, o_mm, o_ss;
      logic o_pm, o_sec, o_day, o_err;
      n     = (i == 0) ? "h24" : "h12";
      hr    = secs[i] / 3600;
      hdisp = (i == 0) ? hr : ((hr % 12 == 0) ? 12 : hr % 12);
      if (i == 0) begin
        o_hh = hh_a; o_mm = mm_a; o_ss = ss_a;
        o_pm = pm_a; o_sec = sec_a; o_day = day_a; o_err = err_a;
      end else begin
        o_hh = hh_b; o_mm = mm_b; o_ss = ss_b;
        o_pm = pm_b; o_sec = sec_b; o_day = day_b; o_err = err_b;
      end
      check({n, "_hh"}, 32'(o_hh), 32'(to_bcd(hdisp)));
      check({n, "_mm"}, 32'(o_mm), 32'(to_bcd((secs[i] / 60) % 60)));
      check({n, "_ss"}, 32'(o_ss), 32'(to_bcd(secs[i] % 60)));
      check({n, "_pm"}, 32'(o_pm), 32'((i == 1) && (hr >= 12)));
      check({n, "_sec_pulse"}, 32'(o_sec), 32'(exp_sec[i]));
      check({n, "_day_pulse"}, 32'(o_day), 32'(exp_day[i]));
      check({n, "_load_err"}, 32'(o_err), 32'(exp_err[i]));
    end
  endtask

  // One clk cycle: inputs were set before the call (at a falling edge). The
  // model updates at the rising edge, and outputs are compared at the next
  // falling edge.
  task automatic cycle();
    bit rise;
    @(posedge clk);
    rise = tick && !m_tick_q;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        exp_sec[i] = 1'b0;
        exp_day[i] = 1'b0;
        exp_err[i] = 1'b0;
        if (load) begin
          if (load_valid(i == 1, load_hh, load_mm, load_ss))
            secs[i] = load_secs(i == 1, load_hh, load_mm, load_ss, load_pm);
          else
            exp_err[i] = 1'b1;
        end else if (rise && run) begin
          exp_sec[i] = 1'b1;
          exp_day[i] = (secs[i] == 86399);
          secs[i]    = (secs[i] + 1) % 86400;
        end
      end
      m_tick_q = tick;
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic step(input bit t, input bit r);
    tick = t; run = r; load = 1'b0;
    cycle();
  endtask

  task automatic load_time(input logic [7:0] h, input logic [7:0] m,
                           input logic [7:0] s, input bit p, input bit t);
    load_hh = h; load_mm = m; load_ss = s; load_pm = p;
    load = 1'b1; tick = t; run = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    compare_all();                       // reset state
    step(1'b1, 1'b1);                    // held in reset despite tick/run
    load = 1'b1; load_hh = 8'h05; tick = 1'b0; run = 1'b1;
    cycle();
    load = 1'b0;
    rst_n = 1'b1;

    // 24h rollover with day_pulse.
    load_time(8'h23, 8'h59, 8'h58, 1'b0, 1'b0);
    step(1'b1, 1'b1);
    check("r029_ss_59", 32'(ss_a), 32'h59);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("r029_hh_00", 32'(hh_a), 32'h00);
    check("r029_ss_00", 32'(ss_a), 32'h00);
    check("r029_day", 32'(day_a), 32'h1);
    check("r029_sec", 32'(sec_a), 32'h1);
    step(1'b0, 1'b1);
    check("r029_day_end", 32'(day_a), 32'h0);

    // 12h noon/midnight behaviour.
    load_time(8'h11, 8'h59, 8'h59, 1'b0, 1'b0);
    step(1'b1, 1'b1);
    check("r030_noon_hh", 32'(hh_b), 32'h12);
    check("r030_noon_pm", 32'(pm_b), 32'h1);
    check("r030_noon_day", 32'(day_b), 32'h0);
    step(1'b0, 1'b1);
    load_time(8'h11, 8'h59, 8'h59, 1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("r030_mid_hh", 32'(hh_b), 32'h12);
    check("r030_mid_pm", 32'(pm_b), 32'h0);
    check("r030_mid_day", 32'(day_b), 32'h1);
    step(1'b0, 1'b1);

    // tick held high for 10 cycles gives one advance.
    load_time(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (10) step(1'b1, 1'b1);
    check("r031_ss", 32'(ss_a), 32'h01);
    step(1'b0, 1'b1);

    // Rejected loads and load coincident with an edge.
    load_time(8'h00, 8'h60, 8'h00, 1'b0, 1'b0);
    check("r032_mm60_err", 32'(err_a), 32'h1);
    check("r032_mm60_ss", 32'(ss_a), 32'h01);
    step(1'b0, 1'b1);
    load_time(8'h00, 8'h10, 8'h20, 1'b0, 1'b0);
    check("r032_hh00_err12", 32'(err_b), 32'h1);
    load_time(8'h01, 8'h02, 8'h0A, 1'b0, 1'b0);
    check("r032_digitA_err", 32'(err_a), 32'h1);
    load_time(8'h07, 8'h08, 8'h09, 1'b1, 1'b1);
    check("r032_coinc_ss", 32'(ss_a), 32'h09);
    check("r032_coinc_sec", 32'(sec_a), 32'h0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);

    // run=0 discards edges; run=1 resumes with exactly one second per edge.
    load_time(8'h00, 8'h00, 8'h10, 1'b0, 1'b0);
    repeat (3) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    check("r033_hold_ss", 32'(ss_a), 32'h10);
    step(1'b1, 1'b1);
    check("r033_resume_ss", 32'(ss_a), 32'h11);
    step(1'b0, 1'b1);

    // Asynchronous reset mid-count, asserted between clk edges.
    load_time(8'h12, 8'h34, 8'h56, 1'b0, 1'b0);
    step(1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    check("r034_hh12", 32'(hh_b), 32'h12);
    check("r034_ss24", 32'(ss_a), 32'h00);
    @(negedge clk);
    load = 1'b1; load_hh = 8'h05; tick = 1'b0; run = 1'b1;
    cycle();
    load = 1'b0;
    tick = 1'b1; run = 1'b1; rst_n = 1'b1;
    cycle();                             // tick already high counts as an edge
    check("r034_resume_ss", 32'(ss_a), 32'h01);
    step(1'b0, 1'b1);

    // Randomized traffic, with loads biased toward rollover boundaries.
    for (int n = 0; n < 3000; n++) begin
      tick = ($urandom_range(0, 2) != 0) ? ~tick : tick;
      run  = ($urandom_range(0, 7) != 0);
      load = ($urandom_range(0, 31) == 0);
      load_pm = 1'($urandom_range(0, 1));
      if (load) begin
        case ($urandom_range(0, 2))
          0: begin
            load_hh = 8'($urandom); load_mm = 8'($urandom); load_ss = 8'($urandom);
          end
          1: begin
            load_hh = to_bcd(int'($urandom_range(0, 23)));
            load_mm = to_bcd(int'($urandom_range(0, 59)));
            load_ss = to_bcd(int'($urandom_range(0, 59)));
          end
          default: begin
            load_hh = to_bcd(($urandom_range(0, 1) != 0) ? 11 : 23);
            load_mm = 8'h59;
            load_ss = to_bcd(int'($urandom_range(55, 59)));
          end
        endcase
      end
      cycle();
    end
    load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
